// File: rtl/pwm_generador.sv
// pwm_generador: prescaled PWM generator; duty is latched only at period wrap so the output never glitches.
module pwm_generador #(
  parameter int BITS_DUTY   = 8,
  parameter int DIV_PRESC   = 4,
  parameter int ANCHO_PRESC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [BITS_DUTY-1:0] dato_duty,
  output logic                 pwm_out,
  output logic                 fin_periodo,
  output logic [BITS_DUTY-1:0] duty_actual
);
  logic [ANCHO_PRESC-1:0] r_pc;
  logic [BITS_DUTY-1:0]   r_cnt;
  logic [BITS_DUTY-1:0]   r_duty;
  logic                   r_pwm;
  logic                   r_fin;
  logic                   w_tick;
  logic                   w_wrap;
  assign w_tick      = en && (r_pc == ANCHO_PRESC'(DIV_PRESC - 1));
  assign w_wrap      = w_tick && (r_cnt == {BITS_DUTY{1'b1}});
  assign pwm_out     = r_pwm;
  assign fin_periodo = r_fin;
  assign duty_actual = r_duty;
  // Idle keeps tracking dato_duty so the first period after enable uses the freshest value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
      r_fin  <= 1'b0;
    end else if (!en) begin
      r_pc   <= '0;
      r_cnt  <= '0;
      r_duty <= dato_duty;
      r_pwm  <= 1'b0;
      r_fin  <= 1'b0;
    end else begin
      r_pc   <= w_tick ? '0 : r_pc + ANCHO_PRESC'(1);
      r_cnt  <= w_tick ? r_cnt + BITS_DUTY'(1) : r_cnt;
      r_duty <= w_wrap ? dato_duty : r_duty;
      r_pwm  <= r_cnt < r_duty;
      r_fin  <= w_wrap;
    end
  end
endmodule

// File: tb/tb_pwm_generador.sv
// tb_pwm_generador: scoreboard of per-period high time, period length and latched duty for two prescaler settings.
module tb_pwm_generador;
  typedef struct {
    int         hi;
    int         len;
    logic [7:0] duty;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1 = 1'b0, en4 = 1'b0;
  logic [7:0] d1 = '0, d4 = '0;
  logic       p1, f1, p4, f4;
  logic [7:0] a1, a4;
  exp_t       q[2][$];
  int         hi[2];
  int         len[2];
  int         total = 0;
  int         bad = 0;
  always #5 clk = ~clk;
  pwm_generador #(.BITS_DUTY(8), .DIV_PRESC(1), .ANCHO_PRESC(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .dato_duty(d1),
    .pwm_out(p1), .fin_periodo(f1), .duty_actual(a1)
  );
  pwm_generador #(.BITS_DUTY(8), .DIV_PRESC(4), .ANCHO_PRESC(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .dato_duty(d4),
    .pwm_out(p4), .fin_periodo(f4), .duty_actual(a4)
  );
  task automatic mon(input int i, input logic e, input logic p, input logic f, input logic [7:0] d);
    exp_t x;
    if (!rst_n || !e) begin
      total++;
      if (p !== 1'b0 || f !== 1'b0) begin
        bad++;
        $display("FAIL idle%0d: pwm=%b fin=%b, required 0 0", i, p, f);
      end
      hi[i]  = 0;
      len[i] = 0;
    end else begin
      hi[i]  += int'(p);
      len[i] += 1;
      if (f === 1'b1) begin
        total++;
        if (q[i].size() == 0) begin
          bad++;
          $display("FAIL unexpected_fin%0d: strobe after %0d clocks, none expected", i, len[i]);
        end else begin
          x = q[i].pop_front();
          if (hi[i] !== x.hi || len[i] !== x.len || d !== x.duty) begin
            bad++;
            $display("FAIL period%0d: hi=%0d len=%0d duty=%0d, required hi=%0d len=%0d duty=%0d",
                     i, hi[i], len[i], d, x.hi, x.len, x.duty);
          end
        end
        hi[i]  = 0;
        len[i] = 0;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
    mon(0, en1, p1, f1, a1);
    mon(1, en4, p4, f4, a4);
    @(negedge clk);
  endtask
  task automatic push(input int i, input int n, input int h, input int l, input logic [7:0] d);
    exp_t x;
    x.hi = h;
    x.len = l;
    x.duty = d;
    for (int k = 0; k < n; k++) q[i].push_back(x);
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    total++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      bad++;
      $display("FAIL timeout: %0d/%0d periods still pending, required 0", q[0].size(), q[1].size());
      q[0].delete();
      q[1].delete();
    end
  endtask
  task automatic start1(input logic [7:0] d);
    en1 = 1'b0;
    d1 = d;
    cyc();
    cyc();
    en1 = 1'b1;
  endtask
  task automatic test_reset();
    #3;
    total++;
    if (p1 !== 1'b0 || f1 !== 1'b0 || a1 !== 8'd0 || p4 !== 1'b0 || f4 !== 1'b0 || a4 !== 8'd0) begin
      bad++;
      $display("FAIL reset: p1=%b f1=%b a1=%0d p4=%b f4=%b a4=%0d, required all 0", p1, f1, a1, p4, f4, a4);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    d1 = 8'd64;
    repeat (3) cyc();
    total++;
    if (a1 !== 8'd64 || p1 !== 1'b0) begin
      bad++;
      $display("FAIL idle_latch: duty=%0d pwm=%b, required 64 0", a1, p1);
    end
  endtask
  task automatic test_duty64();
    start1(8'd64);
    push(0, 3, 64, 256, 8'd64);
    wait_done(900);
  endtask
  task automatic test_extremes();
    start1(8'd0);
    push(0, 3, 0, 256, 8'd0);
    wait_done(900);
    start1(8'd255);
    push(0, 3, 255, 256, 8'd255);
    wait_done(900);
  endtask
  task automatic test_presc4();
    en1 = 1'b0;
    d4 = 8'd128;
    cyc();
    cyc();
    en4 = 1'b1;
    push(1, 2, 512, 1024, 8'd128);
    wait_done(2200);
    en4 = 1'b0;
  endtask
  task automatic test_change();
    start1(8'd64);
    push(0, 1, 64, 256, 8'd200);
    push(0, 1, 200, 256, 8'd200);
    repeat (100) cyc();
    d1 = 8'd200;
    wait_done(600);
  endtask
  task automatic test_idle();
    start1(8'd64);
    repeat (150) cyc();
    en1 = 1'b0;
    d1 = 8'd30;
    repeat (10) cyc();
    total++;
    if (a1 !== 8'd30) begin
      bad++;
      $display("FAIL idle_duty: duty=%0d, required 30", a1);
    end
    en1 = 1'b1;
    push(0, 1, 30, 256, 8'd30);
    wait_done(300);
  endtask
  task automatic test_async_reset();
    start1(8'd100);
    repeat (50) cyc();
    total++;
    if (p1 !== 1'b1) begin
      bad++;
      $display("FAIL high_phase: pwm=%b, required 1", p1);
    end
    #2;
    rst_n = 1'b0;
    en1 = 1'b0;
    #1;
    total++;
    if (p1 !== 1'b0 || f1 !== 1'b0 || a1 !== 8'd0) begin
      bad++;
      $display("FAIL async_reset: pwm=%b fin=%b duty=%0d, required 0 0 0", p1, f1, a1);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    en1 = 1'b1;
    push(0, 1, 100, 256, 8'd100);
    wait_done(300);
  endtask
  initial begin
    test_reset();
    test_duty64();
    test_extremes();
    test_presc4();
    test_change();
    test_idle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
